// File: rtl/rvfi_tracker_pkg.sv
// Shared payload type and widths for the RVFI shadow pipeline.
// Payload fields are XLEN_MAX wide; the top zero-extends in and slices out at XLEN.
package rvfi_tracker_pkg;

  localparam int MASK_W   = 4;
  localparam int REG_W    = 5;
  localparam int XLEN_MAX = 64;

  typedef struct packed {
    logic [31:0]         inst;
    logic [XLEN_MAX-1:0] pc_rdata;
    logic [XLEN_MAX-1:0] pc_wdata;
    logic [REG_W-1:0]    rs1_addr;
    logic [REG_W-1:0]    rs2_addr;
    logic [XLEN_MAX-1:0] rs1_rdata;
    logic [XLEN_MAX-1:0] rs2_rdata;
    logic [REG_W-1:0]    rd_addr;
    logic [XLEN_MAX-1:0] mem_addr;
    logic [MASK_W-1:0]   mem_rmask;
    logic [MASK_W-1:0]   mem_wmask;
    logic [XLEN_MAX-1:0] mem_rdata;
    logic [XLEN_MAX-1:0] mem_wdata;
  } rvfi_entry_t;

  function automatic logic [MASK_W-1:0] gate_mask(input logic en, input logic [MASK_W-1:0] mbe);
    return en ? mbe : '0;
  endfunction

endpackage

// File: rtl/rvfi_shadow_stage.sv
// One shadow stage: valid + payload register with advance, hold and kill.
// The stage after the memory stage overwrites the memory fields from the live bus.
module rvfi_shadow_stage
  import rvfi_tracker_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter bit MEM_CAPTURE = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              kill,
  input  logic              vld_i,
  input  rvfi_entry_t       ent_i,
  input  logic              mem_read_i,
  input  logic              mem_write_i,
  input  logic [XLEN-1:0]   mem_addr_i,
  input  logic [XLEN-1:0]   mem_wdata_i,
  input  logic [XLEN-1:0]   mem_rdata_i,
  input  logic [MASK_W-1:0] mem_mbe_i,
  output logic              vld_o,
  output rvfi_entry_t       ent_o
);

  logic        vld_q, vld_d;
  rvfi_entry_t ent_q, ent_d;
  logic        unused_mem;

  assign unused_mem = ^{mem_read_i, mem_write_i, mem_addr_i, mem_wdata_i, mem_rdata_i, mem_mbe_i};

  // Kill applies after advance/hold, so it hits whichever entry ends up here.
  always_comb begin
    vld_d = (stall ? vld_q : vld_i) & ~kill;
    ent_d = ent_q;
    if (!stall) begin
      ent_d = ent_i;
      if (MEM_CAPTURE) begin
        ent_d.mem_addr  = XLEN_MAX'(mem_addr_i);
        ent_d.mem_wdata = XLEN_MAX'(mem_wdata_i);
        ent_d.mem_rdata = XLEN_MAX'(mem_rdata_i);
        ent_d.mem_rmask = gate_mask(mem_read_i, mem_mbe_i);
        ent_d.mem_wmask = gate_mask(mem_write_i, mem_mbe_i);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      vld_q <= 1'b0;
      ent_q <= '0;
    end else begin
      vld_q <= vld_d;
      ent_q <= ent_d;
    end
  end

  assign vld_o = vld_q;
  assign ent_o = ent_q;

endmodule

// File: rtl/rvfi_commit_tracker.sv
// RVFI shadow pipeline: DEPTH stages (2..8) carrying monitor data, plus commit order,
// halt detection and a stall watchdog at the last stage. XLEN must not exceed 64.
module rvfi_commit_tracker
  import rvfi_tracker_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int DEPTH     = 2,
  parameter int MEM_STAGE = 0,
  parameter int ORDER_W   = 64,
  parameter int TIMEOUT   = 1024
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               stall,
  input  logic [DEPTH-1:0]   flush,
  input  logic               in_valid,
  input  logic [31:0]        in_inst,
  input  logic [XLEN-1:0]    in_pc_rdata,
  input  logic [XLEN-1:0]    in_pc_wdata,
  input  logic [REG_W-1:0]   in_rs1_addr,
  input  logic [REG_W-1:0]   in_rs2_addr,
  input  logic [XLEN-1:0]    in_rs1_rdata,
  input  logic [XLEN-1:0]    in_rs2_rdata,
  input  logic [REG_W-1:0]   in_rd_addr,
  input  logic               mem_read,
  input  logic               mem_write,
  input  logic [XLEN-1:0]    mem_addr,
  input  logic [XLEN-1:0]    mem_wdata,
  input  logic [XLEN-1:0]    mem_rdata,
  input  logic [MASK_W-1:0]  mem_mbe,
  input  logic               wb_load_regfile,
  input  logic [XLEN-1:0]    wb_rd_wdata,
  output logic               commit,
  output logic [ORDER_W-1:0] order,
  output logic               halt,
  output logic               halted,
  output logic               timeout,
  output logic [31:0]        rvfi_inst,
  output logic [XLEN-1:0]    rvfi_pc_rdata,
  output logic [XLEN-1:0]    rvfi_pc_wdata,
  output logic [REG_W-1:0]   rvfi_rs1_addr,
  output logic [REG_W-1:0]   rvfi_rs2_addr,
  output logic [XLEN-1:0]    rvfi_rs1_rdata,
  output logic [XLEN-1:0]    rvfi_rs2_rdata,
  output logic [REG_W-1:0]   rvfi_rd_addr,
  output logic [XLEN-1:0]    rvfi_rd_wdata,
  output logic [XLEN-1:0]    rvfi_mem_addr,
  output logic [MASK_W-1:0]  rvfi_mem_rmask,
  output logic [MASK_W-1:0]  rvfi_mem_wmask,
  output logic [XLEN-1:0]    rvfi_mem_rdata,
  output logic [XLEN-1:0]    rvfi_mem_wdata
);

  localparam int WD_W = $clog2(TIMEOUT + 1);

  logic [DEPTH-1:0] stage_vld;
  rvfi_entry_t      stage_ent [DEPTH];
  rvfi_entry_t      in_ent;
  rvfi_entry_t      tail;
  logic             unused_tail;

  logic [ORDER_W-1:0] order_q, order_d;
  logic               halted_q, halted_d;
  logic [WD_W-1:0]    wd_q, wd_d;
  logic               timeout_q, timeout_d;

  always_comb begin
    in_ent           = '0;
    in_ent.inst      = in_inst;
    in_ent.pc_rdata  = XLEN_MAX'(in_pc_rdata);
    in_ent.pc_wdata  = XLEN_MAX'(in_pc_wdata);
    in_ent.rs1_addr  = in_rs1_addr;
    in_ent.rs2_addr  = in_rs2_addr;
    in_ent.rs1_rdata = XLEN_MAX'(in_rs1_rdata);
    in_ent.rs2_rdata = XLEN_MAX'(in_rs2_rdata);
    in_ent.rd_addr   = in_rd_addr;
  end

  for (genvar k = 0; k < DEPTH; k++) begin : g_stage
    logic        vld_in;
    rvfi_entry_t ent_in;
    if (k == 0) begin : g_head
      assign vld_in = in_valid;
      assign ent_in = in_ent;
    end else begin : g_body
      assign vld_in = stage_vld[k-1];
      assign ent_in = stage_ent[k-1];
    end
    rvfi_shadow_stage #(
      .XLEN        (XLEN),
      .MEM_CAPTURE (k == MEM_STAGE + 1)
    ) u_stage (
      .clk         (clk),
      .rst         (rst),
      .stall       (stall),
      .kill        (flush[k]),
      .vld_i       (vld_in),
      .ent_i       (ent_in),
      .mem_read_i  (mem_read),
      .mem_write_i (mem_write),
      .mem_addr_i  (mem_addr),
      .mem_wdata_i (mem_wdata),
      .mem_rdata_i (mem_rdata),
      .mem_mbe_i   (mem_mbe),
      .vld_o       (stage_vld[k]),
      .ent_o       (stage_ent[k])
    );
  end

  assign tail        = stage_ent[DEPTH-1];
  assign unused_tail = ^tail;

  assign commit = stage_vld[DEPTH-1] & ~stall & ~flush[DEPTH-1];
  assign halt   = commit & (tail.pc_wdata == tail.pc_rdata);

  // Watchdog saturates so a very long stall cannot wrap back below TIMEOUT.
  always_comb begin
    order_d   = commit ? order_q + ORDER_W'(1) : order_q;
    halted_d  = halted_q | halt;
    wd_d      = '0;
    if (stall) wd_d = (wd_q == WD_W'(TIMEOUT)) ? wd_q : wd_q + WD_W'(1);
    timeout_d = timeout_q | (wd_d == WD_W'(TIMEOUT));
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      order_q   <= '0;
      halted_q  <= 1'b0;
      wd_q      <= '0;
      timeout_q <= 1'b0;
    end else begin
      order_q   <= order_d;
      halted_q  <= halted_d;
      wd_q      <= wd_d;
      timeout_q <= timeout_d;
    end
  end

  assign order   = order_q;
  assign halted  = halted_q;
  assign timeout = timeout_q;

  assign rvfi_inst      = tail.inst;
  assign rvfi_pc_rdata  = tail.pc_rdata[XLEN-1:0];
  assign rvfi_pc_wdata  = tail.pc_wdata[XLEN-1:0];
  assign rvfi_rs1_addr  = tail.rs1_addr;
  assign rvfi_rs2_addr  = tail.rs2_addr;
  assign rvfi_rs1_rdata = tail.rs1_rdata[XLEN-1:0];
  assign rvfi_rs2_rdata = tail.rs2_rdata[XLEN-1:0];
  assign rvfi_rd_addr   = tail.rd_addr;
  assign rvfi_rd_wdata  = (tail.rd_addr != '0 && wb_load_regfile) ? wb_rd_wdata : '0;
  assign rvfi_mem_addr  = tail.mem_addr[XLEN-1:0];
  assign rvfi_mem_rmask = tail.mem_rmask;
  assign rvfi_mem_wmask = tail.mem_wmask;
  assign rvfi_mem_rdata = tail.mem_rdata[XLEN-1:0];
  assign rvfi_mem_wdata = tail.mem_wdata[XLEN-1:0];

endmodule

// File: tb/tb_rvfi_commit_tracker.sv
// Randomized and directed bench for rvfi_commit_tracker against an array-based model.
module tb_rvfi_commit_tracker;

  localparam int XLEN      = 32;
  localparam int DEPTH     = 2;
  localparam int MEM_STAGE = 0;
  localparam int ORDER_W   = 64;
  localparam int TIMEOUT   = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               rst, stall, in_valid;
  logic [DEPTH-1:0]   flush;
  logic [31:0]        in_inst;
  logic [XLEN-1:0]    in_pc_rdata, in_pc_wdata, in_rs1_rdata, in_rs2_rdata;
  logic [4:0]         in_rs1_addr, in_rs2_addr, in_rd_addr;
  logic               mem_read, mem_write, wb_load_regfile;
  logic [XLEN-1:0]    mem_addr, mem_wdata, mem_rdata, wb_rd_wdata;
  logic [3:0]         mem_mbe;
  logic               commit, halt, halted, timeout;
  logic [ORDER_W-1:0] order;
  logic [31:0]        rvfi_inst;
  logic [XLEN-1:0]    rvfi_pc_rdata, rvfi_pc_wdata, rvfi_rs1_rdata, rvfi_rs2_rdata, rvfi_rd_wdata;
  logic [4:0]         rvfi_rs1_addr, rvfi_rs2_addr, rvfi_rd_addr;
  logic [XLEN-1:0]    rvfi_mem_addr, rvfi_mem_rdata, rvfi_mem_wdata;
  logic [3:0]         rvfi_mem_rmask, rvfi_mem_wmask;

  rvfi_commit_tracker #(
    .XLEN(XLEN), .DEPTH(DEPTH), .MEM_STAGE(MEM_STAGE), .ORDER_W(ORDER_W), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .in_valid(in_valid),
    .in_inst(in_inst), .in_pc_rdata(in_pc_rdata), .in_pc_wdata(in_pc_wdata),
    .in_rs1_addr(in_rs1_addr), .in_rs2_addr(in_rs2_addr),
    .in_rs1_rdata(in_rs1_rdata), .in_rs2_rdata(in_rs2_rdata), .in_rd_addr(in_rd_addr),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_mbe(mem_mbe),
    .wb_load_regfile(wb_load_regfile), .wb_rd_wdata(wb_rd_wdata),
    .commit(commit), .order(order), .halt(halt), .halted(halted), .timeout(timeout),
    .rvfi_inst(rvfi_inst), .rvfi_pc_rdata(rvfi_pc_rdata), .rvfi_pc_wdata(rvfi_pc_wdata),
    .rvfi_rs1_addr(rvfi_rs1_addr), .rvfi_rs2_addr(rvfi_rs2_addr),
    .rvfi_rs1_rdata(rvfi_rs1_rdata), .rvfi_rs2_rdata(rvfi_rs2_rdata),
    .rvfi_rd_addr(rvfi_rd_addr), .rvfi_rd_wdata(rvfi_rd_wdata),
    .rvfi_mem_addr(rvfi_mem_addr), .rvfi_mem_rmask(rvfi_mem_rmask),
    .rvfi_mem_wmask(rvfi_mem_wmask), .rvfi_mem_rdata(rvfi_mem_rdata),
    .rvfi_mem_wdata(rvfi_mem_wdata)
  );

  // Model: one slot per pipeline position holding what the instruction there must report.
  typedef struct {
    logic            v;
    logic [31:0]     inst;
    logic [XLEN-1:0] pcr, pcw, r1d, r2d, maddr, mrd, mwd;
    logic [4:0]      r1a, r2a, rd;
    logic [3:0]      rm, wm;
  } ment_t;

  ment_t           m [DEPTH];
  logic [63:0]     m_order;
  logic            m_halted, m_timeout;
  int              m_wd;
  int              checks = 0;
  int              failures = 0;

  logic            s_commit, s_halt, s_halted, s_timeout;
  logic [63:0]     s_order;
  logic [XLEN-1:0] s_pc, s_maddr, s_mrdata, s_mwdata;
  logic [3:0]      s_rmask, s_wmask;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    for (int k = 0; k < DEPTH; k++) m[k] = '{default: 0};
    m_order = 0; m_halted = 0; m_timeout = 0; m_wd = 0;
  endtask

  task automatic compare();
    ment_t t;
    logic  ec;
    t  = m[DEPTH-1];
    ec = t.v & ~stall & ~flush[DEPTH-1];
    chk("commit", commit, ec);
    chk("order", order, m_order);
    chk("halt", halt, ec && (t.pcw == t.pcr));
    chk("halted", halted, m_halted);
    chk("timeout", timeout, m_timeout);
    if (ec) begin
      chk("inst", rvfi_inst, t.inst);
      chk("pc_rdata", rvfi_pc_rdata, t.pcr);
      chk("pc_wdata", rvfi_pc_wdata, t.pcw);
      chk("rs", {rvfi_rs1_addr, rvfi_rs2_addr, rvfi_rs1_rdata, rvfi_rs2_rdata},
          {t.r1a, t.r2a, t.r1d, t.r2d});
      chk("rd_addr", rvfi_rd_addr, t.rd);
      chk("rd_wdata", rvfi_rd_wdata, (t.rd != 0 && wb_load_regfile) ? wb_rd_wdata : '0);
      chk("mem_addr", rvfi_mem_addr, t.maddr);
      chk("mem_masks", {rvfi_mem_rmask, rvfi_mem_wmask}, {t.rm, t.wm});
      chk("mem_data", {rvfi_mem_rdata, rvfi_mem_wdata}, {t.mrd, t.mwd});
    end
  endtask

  task automatic model_edge();
    logic ec, eh;
    if (!rst) begin
      model_clear();
      return;
    end
    ec = m[DEPTH-1].v & ~stall & ~flush[DEPTH-1];
    eh = ec && (m[DEPTH-1].pcw == m[DEPTH-1].pcr);
    if (ec) m_order = m_order + 1;
    if (eh) m_halted = 1;
    if (stall) begin
      for (int k = 0; k < DEPTH; k++) m[k].v = m[k].v & ~flush[k];
    end else begin
      for (int k = DEPTH - 1; k > 0; k--) begin
        m[k]   = m[k-1];
        m[k].v = m[k-1].v & ~flush[k];
        if (k == MEM_STAGE + 1) begin
          m[k].maddr = mem_addr;
          m[k].mrd   = mem_rdata;
          m[k].mwd   = mem_wdata;
          m[k].rm    = mem_read ? mem_mbe : 4'h0;
          m[k].wm    = mem_write ? mem_mbe : 4'h0;
        end
      end
      m[0] = '{default: 0};
      m[0].v    = in_valid & ~flush[0];
      m[0].inst = in_inst;
      m[0].pcr  = in_pc_rdata;  m[0].pcw = in_pc_wdata;
      m[0].r1a  = in_rs1_addr;  m[0].r2a = in_rs2_addr;
      m[0].r1d  = in_rs1_rdata; m[0].r2d = in_rs2_rdata;
      m[0].rd   = in_rd_addr;
    end
    m_wd = stall ? ((m_wd < TIMEOUT) ? m_wd + 1 : m_wd) : 0;
    if (m_wd == TIMEOUT) m_timeout = 1;
  endtask

  task automatic cyc();
    @(negedge clk);
    compare();
    s_commit = commit; s_order = order; s_halt = halt; s_halted = halted;
    s_timeout = timeout; s_pc = rvfi_pc_rdata; s_maddr = rvfi_mem_addr;
    s_mrdata = rvfi_mem_rdata; s_mwdata = rvfi_mem_wdata;
    s_rmask = rvfi_mem_rmask; s_wmask = rvfi_mem_wmask;
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic issue(input logic v, input logic [XLEN-1:0] pc, input logic [XLEN-1:0] pcw);
    in_valid = v; in_pc_rdata = pc; in_pc_wdata = pcw;
    in_inst = $urandom; in_rs1_addr = 5'($urandom); in_rs2_addr = 5'($urandom);
    in_rs1_rdata = $urandom; in_rs2_rdata = $urandom; in_rd_addr = 5'($urandom);
    wb_load_regfile = 1'($urandom); wb_rd_wdata = $urandom;
  endtask

  task automatic mem_idle();
    mem_read = 0; mem_write = 0; mem_mbe = 0; mem_addr = 0; mem_wdata = 0; mem_rdata = 0;
  endtask

  task automatic do_reset();
    rst = 0; cyc(); cyc(); rst = 1;
  endtask

  initial begin
    stall = 0; flush = '0; mem_idle(); issue(0, 0, 4);
    model_clear();
    rst = 0;
    @(posedge clk); #1;
    cyc();
    rst = 1;
    cyc();
    chk("rst_commit", s_commit, 0);
    chk("rst_order", s_order, 0);
    chk("rst_pc", s_pc, 0);
    chk("rst_flags", {s_halted, s_timeout}, 0);

    // Back-to-back stream
    issue(1, 32'h60, 32'h64); cyc();
    issue(1, 32'h64, 32'h68); cyc();
    issue(1, 32'h68, 32'h6c); cyc();
    chk("b2b0_commit", s_commit, 1); chk("b2b0_pc", s_pc, 32'h60); chk("b2b0_order", s_order, 0);
    issue(0, 32'h0, 32'h4); cyc();
    chk("b2b1_pc", s_pc, 32'h64); chk("b2b1_order", s_order, 1);
    cyc();
    chk("b2b2_pc", s_pc, 32'h68); chk("b2b2_order", s_order, 2);
    cyc();
    chk("b2b_idle", s_commit, 0);

    // Stall hold then single commit
    do_reset();
    issue(1, 32'h70, 32'h74); cyc();
    issue(0, 32'h0, 32'h4); cyc();
    stall = 1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("stall_hold", s_commit, 0);
    end
    stall = 0; cyc();
    chk("stall_commit", s_commit, 1); chk("stall_pc", s_pc, 32'h70); chk("stall_order", s_order, 0);
    cyc();
    chk("stall_once", s_commit, 0); chk("stall_order_inc", s_order, 1);

    // Load then store capture
    do_reset();
    issue(1, 32'h90, 32'h94); cyc();
    issue(0, 32'h0, 32'h4);
    mem_read = 1; mem_mbe = 4'h3; mem_addr = 32'h1000; mem_rdata = 32'hDEADBEEF; cyc();
    mem_idle(); cyc();
    chk("ld_commit", s_commit, 1); chk("ld_rmask", s_rmask, 4'h3); chk("ld_wmask", s_wmask, 0);
    chk("ld_addr", s_maddr, 32'h1000); chk("ld_rdata", s_mrdata, 32'hDEADBEEF);
    issue(1, 32'h94, 32'h98); cyc();
    issue(0, 32'h0, 32'h4);
    mem_write = 1; mem_mbe = 4'h3; mem_addr = 32'h1004; mem_wdata = 32'hCAFEF00D; cyc();
    mem_idle(); cyc();
    chk("st_commit", s_commit, 1); chk("st_wmask", s_wmask, 4'h3); chk("st_rmask", s_rmask, 0);
    chk("st_wdata", s_mwdata, 32'hCAFEF00D);

    // Flush of stage 0 entry
    do_reset();
    issue(1, 32'hA0, 32'hA4); cyc();
    issue(1, 32'hA4, 32'hA8); flush = 2'b01; cyc();
    flush = '0; issue(1, 32'hA8, 32'hAC); cyc();
    chk("fl_a_pc", s_pc, 32'hA0); chk("fl_a_order", s_order, 0);
    issue(0, 32'h0, 32'h4); cyc();
    chk("fl_killed", s_commit, 0);
    cyc();
    chk("fl_c_commit", s_commit, 1); chk("fl_c_pc", s_pc, 32'hA8); chk("fl_c_order", s_order, 1);

    // Self-loop halt
    do_reset();
    issue(1, 32'h80, 32'h80); in_inst = 32'h0000006f; cyc();
    issue(0, 32'h0, 32'h4); cyc();
    cyc();
    chk("halt_pulse", {s_commit, s_halt, s_halted}, 3'b110);
    cyc();
    chk("halted_set", {s_halt, s_halted}, 2'b01);
    cyc();
    chk("halted_sticky", s_halted, 1);
    do_reset(); cyc();
    chk("halted_cleared", s_halted, 0);

    // Watchdog
    stall = 1;
    for (int i = 0; i < 8; i++) cyc();
    chk("wd_before", s_timeout, 0);
    stall = 0; cyc();
    chk("wd_fire", s_timeout, 1);
    cyc();
    chk("wd_sticky", s_timeout, 1);

    // Randomized traffic with occasional resets and long stall bursts
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      logic [31:0] pc;
      pc = $urandom & 32'hFFFF_FFFC;
      issue(1'($urandom_range(3) != 0), pc, ($urandom_range(15) == 0) ? pc : $urandom);
      stall = ((i % 400) >= 390) ? 1'b1 : ($urandom_range(3) == 0);
      flush = ($urandom_range(7) == 0) ? DEPTH'($urandom) : '0;
      rst = ($urandom_range(299) != 0);
      mem_read = 1'($urandom); mem_write = 1'($urandom); mem_mbe = 4'($urandom);
      mem_addr = $urandom; mem_wdata = $urandom; mem_rdata = $urandom;
      cyc();
    end

    // Reset in the middle of a flowing stream
    rst = 1; stall = 0; flush = '0;
    for (int i = 0; i < 4; i++) begin issue(1, 32'h200 + 4 * i, 32'h300); cyc(); end
    rst = 0; cyc();
    rst = 1; issue(0, 32'h0, 32'h4); cyc();
    chk("mid_rst_commit", s_commit, 0); chk("mid_rst_order", s_order, 0);
    chk("mid_rst_flags", {s_halted, s_timeout}, 0);
    issue(1, 32'h400, 32'h404); cyc(); issue(0, 32'h0, 32'h4); cyc(); cyc();
    chk("mid_rst_restart", {s_commit, s_order}, {1'b1, 64'd0});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rvfi_commit_tracker.md
Name: rvfi_commit_tracker

Overview:
Synthesizable shadow pipeline that carries per-instruction RVFI monitor data through the processor pipeline alongside the datapath registers. It is parametrised in pipeline depth, data width and memory-capture stage, and honours a global stall plus per-stage flush (kill). At the last stage it produces commit, order, halt, a sticky halted flag and a stall watchdog. It sits in the testbench/monitor layer between the datapath probes and the RVFI interface.

Parameters:
XLEN, 32, data/address width
DEPTH, 2, number of shadow stages (stage 0 = EX/MEM, stage DEPTH-1 = MEM/WB); legal range 2..8
MEM_STAGE, 0, stage whose outgoing transfer samples memory fields; legal range 0..DEPTH-2
ORDER_W, 64, width of the order counter
TIMEOUT, 1024, consecutive stall cycles before watchdog fires; must be >0

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-low
stall  in  1  global pipeline stall; when high all stages hold
flush  in  DEPTH  per-stage kill; bit k clears the valid bit of stage k
in_valid  in  1  stage-0 entry carries a real instruction
in_inst  in  32  instruction word
in_pc_rdata  in  XLEN  instruction PC
in_pc_wdata  in  XLEN  next PC
in_rs1_addr, in_rs2_addr  in  5 each  source register indices
in_rs1_rdata, in_rs2_rdata  in  XLEN each  forwarded source operands
in_rd_addr  in  5  destination index
mem_read, mem_write  in  1 each  memory operation flags of the instruction leaving MEM_STAGE
mem_addr, mem_wdata, mem_rdata  in  XLEN each  memory bus values
mem_mbe  in  4  byte enables
wb_load_regfile  in  1  live write-back enable
wb_rd_wdata  in  XLEN  live write-back data
commit  out  1  instruction retires this cycle
order  out  ORDER_W  retirement index of the committing instruction
halt  out  1  commit of a self-loop (pc_wdata == pc_rdata)
halted  out  1  sticky halt flag
timeout  out  1  sticky stall-watchdog flag
rvfi_*  out  various  inst, pc_rdata, pc_wdata, rs1/rs2 addr+rdata, rd_addr, rd_wdata, mem_addr, mem_rmask, mem_wmask, mem_rdata, mem_wdata, all from stage DEPTH-1; rd_wdata forced 0 when rd_addr==0 or load_regfile low

Behaviour:
- Reset (rst low at a clk edge): all valid bits 0, all payload 0, order 0, stall counter 0, halted 0, timeout 0. Reset overrides stall and flush. Reset mid-stream discards every in-flight entry.
- Advance: when stall is low, each stage k>0 loads stage k-1 and stage 0 loads the in_* inputs with valid = in_valid. When stall is high, payload holds.
- Flush: takes effect at the same edge and after advance: next valid[k] = (stall ? valid[k] : valid[k-1]/in_valid) & ~flush[k]. Flush with stall low kills the entry arriving in stage k. Flush with stall high kills the held entry.
- Memory capture: on advance out of stage MEM_STAGE, stage MEM_STAGE+1 samples mem_addr/wdata/rdata. rmask = mem_read ? mem_mbe : 0. wmask = mem_write ? mem_mbe : 0. Other stages pass memory fields through unchanged.
- commit = valid[DEPTH-1] & ~stall & ~flush[DEPTH-1]. This is combinational; the entry leaves at that edge. An entry that stays stalled commits once, in its last stall-free cycle.
- order output equals the counter value. The counter increments by 1 on each commit edge and wraps modulo 2^ORDER_W.
- halt = commit & (rvfi_pc_wdata == rvfi_pc_rdata). halted is set on the edge after halt and stays set until reset. Commits continue after halted is set.
- Watchdog: the counter increments while stall is high, saturating at TIMEOUT, and clears when stall is low. timeout is set when the counter reaches TIMEOUT and is sticky until reset.
- Latency: an entry captured at edge N reaches stage DEPTH-1 at edge N+DEPTH-1, absent stall. It commits in the following stall-free cycle.

Decomposition:
- Package rvfi_tracker_pkg holds typedef rvfi_entry_t (packed struct of all payload fields) and localparam constants for mask width (4) and register-index width (5).
- One sub-module, rvfi_shadow_stage: a single valid+payload register with advance/hold/kill and optional memory capture, enabled by a parameter. The top generates DEPTH instances and holds the order counter, halt flag and watchdog.

Test Plan:
- DEPTH=2, no stall: three back-to-back valid instructions at PCs 0x60,0x64,0x68 -> commit high in cycles 2,3,4 with order 0,1,2 and rvfi_pc_rdata matching.
- Stall held 3 cycles with a valid entry in stage DEPTH-1 -> commit low for 3 cycles, then exactly one commit with unchanged payload; order increments once.
- Load at stage 0 with mem_read=1, mem_mbe=0x3, mem_addr=0x1000, mem_rdata=0xDEADBEEF -> at commit rmask=0x3, wmask=0, mem_addr=0x1000, mem_rdata=0xDEADBEEF. Repeat as a store -> wmask=0x3, rmask=0.
- flush=2'b01 with stall low while an entry enters stage 0 -> that instruction never commits; neighbours commit with contiguous order values.
- Commit of `jal x0,0` at PC 0x80 (pc_wdata=0x80) -> halt high that cycle, halted high from the next cycle until rst low.
- TIMEOUT=8, stall held 8 cycles -> timeout rises after the 8th stall edge and stays high after stall drops. Reset mid-stream -> all outputs 0 and order restarts at 0.
